// File: rtl/video_timing_gen.sv
// video_timing_gen: pixel clock-enable, raster counters and sync/blank decode; VIDEO_TIMING_INTERLACE_EN adds interlace/field.
module video_timing_gen #(
  parameter int CE_DIV   = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk_vid,
  input  logic        reset,
  input  logic        enable,
`ifdef VIDEO_TIMING_INTERLACE_EN
  input  logic        interlace,
  output logic        field,
`endif
  output logic        ce_pix,
  output logic        HSync,
  output logic        VSync,
  output logic        HBlank,
  output logic        VBlank,
  output logic [11:0] hcount,
  output logic [10:0] vcount,
  output logic        line_start,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = $clog2(CE_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE = DW'(CE_DIV - 2);
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] HB_START = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] VB_START = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  logic [DW-1:0] r_div;
  logic [11:0]   r_h, w_h_nxt;
  logic [10:0]   r_v, w_v_nxt, w_v_last;
  logic          r_ce, r_ls, r_fs, r_hs, r_vs, r_hb, r_vb;
  logic          w_pix, w_h_wrap, w_v_wrap;
`ifdef VIDEO_TIMING_INTERLACE_EN
  logic r_field;
  // odd fields carry one extra back-porch line
  assign w_v_last = r_field ? V_LAST + 11'd1 : V_LAST;
  assign field = r_field;
`else
  assign w_v_last = V_LAST;
`endif
  always_comb begin
    w_pix = r_div == DIV_PRE;
    w_h_wrap = w_pix && r_h == H_LAST;
    w_v_wrap = w_h_wrap && r_v == w_v_last;
    w_h_nxt = w_h_wrap ? '0 : r_h + 12'(w_pix);
    w_v_nxt = w_v_wrap ? '0 : r_v + 11'(w_h_wrap);
  end
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      r_div <= '0;
      r_h <= '0;
      r_v <= '0;
      r_ce <= 1'b0;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
      r_hs <= 1'b0;
      r_vs <= 1'b0;
      r_hb <= 1'b0;
      r_vb <= 1'b0;
`ifdef VIDEO_TIMING_INTERLACE_EN
      r_field <= 1'b0;
`endif
    end else if (enable) begin
      r_div <= r_div == DIV_LAST ? '0 : r_div + 1'b1;
      r_ce <= w_pix;
      r_h <= w_h_nxt;
      r_v <= w_v_nxt;
      r_ls <= w_h_wrap;
      r_fs <= w_v_wrap;
      r_hb <= w_h_nxt >= HB_START;
      r_hs <= w_h_nxt >= HS_START && w_h_nxt < HS_END;
      r_vb <= w_v_nxt >= VB_START;
      r_vs <= w_v_nxt >= VS_START && w_v_nxt < VS_END;
`ifdef VIDEO_TIMING_INTERLACE_EN
      if (w_v_wrap) r_field <= interlace & ~r_field;
`endif
    end else begin
      r_ce <= 1'b0;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end
  end
  assign ce_pix = r_ce;
  assign line_start = r_ls;
  assign frame_start = r_fs;
  assign HSync = r_hs;
  assign VSync = r_vs;
  assign HBlank = r_hb;
  assign VBlank = r_vb;
  assign hcount = r_h;
  assign vcount = r_v;
endmodule
